// File: rtl/sync_phase_gen_if.sv
// Timing-generator bus: advance tick and mode request in, phase/sync/blank/position decode out.
// Pure wiring; the generator drives the outputs and the consumer drives adv/mode_sel.
interface sync_phase_gen_if #(
    parameter int CW = 11
);
    logic          adv;
    logic          mode_sel;
    logic          sync;
    logic          nblank;
    logic          end_line;
    logic [CW-1:0] pos;
    logic [1:0]    phase;
    logic          mode_q;

    modport master (
        output adv, mode_sel,
        input  sync, nblank, end_line, pos, phase, mode_q
    );

    modport slave (
        input  adv, mode_sel,
        output sync, nblank, end_line, pos, phase, mode_q
    );
endinterface

// File: rtl/sync_phase_gen.sv
// Single-axis video timing generator: SYNC -> BP -> ACTIVE -> FP, stepping on each adv tick.
// Phase decode follows the register one cycle after adv; end_line is same-cycle; no backpressure, adv=0 freezes all state.
module sync_phase_gen #(
    parameter int CW       = 11,
    parameter int SYNC0    = 96,
    parameter int BP0      = 48,
    parameter int ACT0     = 640,
    parameter int FP0      = 16,
    parameter int SYNC1    = 128,
    parameter int BP1      = 88,
    parameter int ACT1     = 800,
    parameter int FP1      = 40,
    parameter int SYNC_POL = 0
) (
    input  logic             sys_clk,
    input  logic             reset,
    sync_phase_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        PH_SYNC = 2'b00,
        PH_BP   = 2'b01,
        PH_ACT  = 2'b10,
        PH_FP   = 2'b11
    } phase_t;

    function automatic bit len_ok(input int l);
        return (l >= 1) && (l <= (1 << CW));
    endfunction

    generate
        if (!(len_ok(SYNC0) && len_ok(BP0) && len_ok(ACT0) && len_ok(FP0) &&
              len_ok(SYNC1) && len_ok(BP1) && len_ok(ACT1) && len_ok(FP1))) begin : g_len_check
            $error("sync_phase_gen: every phase length must lie in 1..2**CW");
        end
    endgenerate

    // Terminal counts are stored as length-1 so a 2**CW-tick phase still fits in CW bits.
    localparam logic [CW-1:0] L_SYNC0 = CW'(SYNC0 - 1);
    localparam logic [CW-1:0] L_BP0   = CW'(BP0 - 1);
    localparam logic [CW-1:0] L_ACT0  = CW'(ACT0 - 1);
    localparam logic [CW-1:0] L_FP0   = CW'(FP0 - 1);
    localparam logic [CW-1:0] L_SYNC1 = CW'(SYNC1 - 1);
    localparam logic [CW-1:0] L_BP1   = CW'(BP1 - 1);
    localparam logic [CW-1:0] L_ACT1  = CW'(ACT1 - 1);
    localparam logic [CW-1:0] L_FP1   = CW'(FP1 - 1);
    localparam logic          SYNC_ACT = (SYNC_POL != 0);

    phase_t        phase_r;
    logic [CW-1:0] cnt;
    logic          mode_r;
    logic [CW-1:0] len_m1;
    logic          last_tick;

    always_comb begin
        len_m1 = L_SYNC0;
        case ({mode_r, phase_r})
            3'b000:  len_m1 = L_SYNC0;
            3'b001:  len_m1 = L_BP0;
            3'b010:  len_m1 = L_ACT0;
            3'b011:  len_m1 = L_FP0;
            3'b100:  len_m1 = L_SYNC1;
            3'b101:  len_m1 = L_BP1;
            3'b110:  len_m1 = L_ACT1;
            default: len_m1 = L_FP1;
        endcase
    end

    assign last_tick = (cnt == len_m1);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            phase_r <= PH_SYNC;
            cnt     <= '0;
            mode_r  <= bus.mode_sel;
        end else if (bus.adv) begin
            if (last_tick) begin
                cnt     <= '0;
                phase_r <= phase_t'(phase_r + 2'd1);
                // Mode only changes on the end_line tick so a line never mixes timing sets.
                if (phase_r == PH_FP) begin
                    mode_r <= bus.mode_sel;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.sync     = (phase_r == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    assign bus.nblank   = (phase_r == PH_ACT);
    assign bus.end_line = (phase_r == PH_FP) & bus.adv & last_tick & ~reset;
    assign bus.pos      = (phase_r == PH_ACT) ? cnt : '0;
    assign bus.phase    = phase_r;
    assign bus.mode_q   = mode_r;

endmodule
